// File: rtl/jt8255_pkg.sv
// Shared encodings for the jt8255 peripheral-side handshake engine.
package jt8255_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_ACK  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_SETUP = 3'd1,
    TX_STB   = 3'd2,
    TX_HOLD  = 3'd3,
    TX_DRAIN = 3'd4
  } tx_state_e;

  // Strobe/handshake pins on the 8255 side are active low.
  localparam logic       PIN_ACTIVE = 1'b0;
  localparam logic       PIN_IDLE   = 1'b1;
  // Port A input floats high when the peripheral is not driving a byte.
  localparam logic [7:0] PA_IDLE    = 8'hff;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jt8255_fifo.sv
// Show-ahead byte FIFO with 2**AW entries; head is valid whenever not empty.
module jt8255_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pops on empty and pushes on full are dropped.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/jt8255_hsk_periph.sv
// Peripheral-side handshake engine for jt8255 port A in mode 1/2.
// Stream handshakes (rx_*, tx_*): a byte moves on a cycle where valid and
// ready are both high at the rising clock edge; ready may depend
// combinationally on state, valid must not depend on ready.
module jt8255_hsk_periph
  import jt8255_pkg::*;
#(
  parameter int AW   = 4,
  parameter int ACKW = 2,
  parameter int STBW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obfn,
  output logic        ackn,
  input  logic [7:0]  pa_din,
  input  logic        ibf,
  output logic        stbn,
  output logic [7:0]  pa_dout,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [AW:0] rx_cnt,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy
);

  localparam int CW = $clog2(max2(ACKW, STBW)) + 1;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic [CW-1:0] stb_cnt_q, stb_cnt_d;
  logic          ackn_q, ackn_d;
  logic          stbn_q, stbn_d;
  logic [7:0]    pa_dout_q, pa_dout_d;
  logic          fifo_push, fifo_full, fifo_empty;

  jt8255_fifo #(.AW(AW)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (pa_din),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_cnt)
  );

  assign rx_valid = ~fifo_empty;
  assign ackn     = ackn_q;
  assign stbn     = stbn_q;
  assign pa_dout  = pa_dout_q;
  // Held low while reset is asserted so nothing is accepted into a dead FSM.
  assign tx_ready = rst_n & (tx_state_q == TX_IDLE) & ~ibf;
  assign busy     = (rx_state_q != RX_IDLE) | (tx_state_q != TX_IDLE);

  // RX: capture a CPU write, pulse ACK, then wait for OBF to clear so one write gives one push.
  always_comb begin
    rx_state_d = rx_state_q;
    ack_cnt_d  = ack_cnt_q;
    ackn_d     = ackn_q;
    fifo_push  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if ((obfn == PIN_ACTIVE) && !fifo_full) begin
          fifo_push  = 1'b1;
          ackn_d     = PIN_ACTIVE;
          ack_cnt_d  = CW'(ACKW - 1);
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (ack_cnt_q == '0) begin
          ackn_d     = PIN_IDLE;
          rx_state_d = RX_WAIT;
        end else begin
          ack_cnt_d = ack_cnt_q - CW'(1);
        end
      end
      RX_WAIT: begin
        if (obfn == PIN_IDLE) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX: present a byte, strobe it in, and keep it stable until the CPU has read it.
  always_comb begin
    tx_state_d = tx_state_q;
    stb_cnt_d  = stb_cnt_q;
    stbn_d     = stbn_q;
    pa_dout_d  = pa_dout_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && !ibf) begin
          pa_dout_d  = tx_data;
          tx_state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        stbn_d     = PIN_ACTIVE;
        stb_cnt_d  = CW'(STBW - 1);
        tx_state_d = TX_STB;
      end
      TX_STB: begin
        if (stb_cnt_q == '0) begin
          stbn_d     = PIN_IDLE;
          tx_state_d = TX_HOLD;
        end else begin
          stb_cnt_d = stb_cnt_q - CW'(1);
        end
      end
      TX_HOLD: begin
        if (ibf) tx_state_d = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (!ibf) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State, pulse counters and pin registers for both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      ack_cnt_q  <= '0;
      stb_cnt_q  <= '0;
      ackn_q     <= PIN_IDLE;
      stbn_q     <= PIN_IDLE;
      pa_dout_q  <= PA_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      ack_cnt_q  <= ack_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      ackn_q     <= ackn_d;
      stbn_q     <= stbn_d;
      pa_dout_q  <= pa_dout_d;
    end
  end

endmodule

// File: tb/tb_jt8255_hsk_periph.sv
// Bench for jt8255_hsk_periph: jt8255 pin models, byte-queue scoreboard, directed tests.
module tb_jt8255_hsk_periph;

  localparam int AW    = 2;
  localparam int ACKW  = 2;
  localparam int STBW  = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rst_n;
  logic        obfn;
  logic        ackn;
  logic [7:0]  pa_din;
  logic        ibf;
  logic        stbn;
  logic [7:0]  pa_dout;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [AW:0] rx_cnt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  jt8255_hsk_periph #(.AW(AW), .ACKW(ACKW), .STBW(STBW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .obfn     (obfn),
    .ackn     (ackn),
    .pa_din   (pa_din),
    .ibf      (ibf),
    .stbn     (stbn),
    .pa_dout  (pa_dout),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_cnt   (rx_cnt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Expected RX FIFO contents in arrival order, plus the byte the DUT must present on port A.
  logic [7:0] exp_q[$];
  logic [7:0] m_pa;
  logic       ackn_prev;
  logic       pop_pend;
  logic       acc_pend;
  logic [7:0] acc_data;
  logic [7:0] pa_din_s;
  int         sb_pre;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pa      = 8'hff;
      ackn_prev = 1'b1;
      pop_pend  = 1'b0;
      acc_pend  = 1'b0;
      acc_data  = 8'h00;
      pa_din_s  = 8'h00;
    end else begin
      sb_pre = exp_q.size();
      if (pop_pend) void'(exp_q.pop_front());
      if (ackn_prev && !ackn) begin
        check1("push_while_not_full", sb_pre < DEPTH, 1'b1);
        exp_q.push_back(pa_din_s);
      end
      if (acc_pend) m_pa = acc_data;
      check_int("rx_cnt", int'(rx_cnt), exp_q.size());
      check1("rx_valid", rx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check8("rx_data", rx_data, exp_q[0]);
      check8("pa_dout", pa_dout, m_pa);
      ackn_prev = ackn;
      pop_pend  = rx_ready && (exp_q.size() != 0);
      acc_pend  = tx_valid && tx_ready;
      acc_data  = tx_data;
      pa_din_s  = pa_din;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write_begin(input logic [7:0] b);
    pa_din = b;
    obfn   = 1'b0;
  endtask

  // jt8255 side: wait for ACK, measure its width, release OBF two cycles after ACK rises.
  task automatic cpu_write_finish(output int lat);
    int low;
    lat = 0;
    while (ackn && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check1("ack_seen", ackn, 1'b0);
    if (ackn) begin
      obfn = 1'b1;
      return;
    end
    low = 0;
    while (!ackn && low < 50) begin
      @(posedge clk); #1;
      low++;
    end
    check_int("ack_width", low, ACKW);
    repeat (2) @(posedge clk);
    #1 obfn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [7:0] b);
    int lat;
    cpu_write_begin(b);
    cpu_write_finish(lat);
    check_int("ack_latency", lat, 1);
  endtask

  task automatic pop_one(input logic [7:0] b);
    check1("pop_valid", rx_valid, 1'b1);
    check8("pop_data", rx_data, b);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  // Producer plus jt8255 IBF model: IBF set after STB rises, cleared by a CPU read 10 cycles later.
  task automatic send_tx(input logic [7:0] b);
    int n;
    int low;
    logic [7:0] rd;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check1("tx_ready_seen", tx_ready, 1'b1);
    if (!tx_ready) begin
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check1("tx_ready_one_cycle", tx_ready, 1'b0);
    check8("tx_pa_dout", pa_dout, b);
    check1("stb_setup", stbn, 1'b1);
    @(posedge clk); #1;
    check1("stb_fall", stbn, 1'b0);
    low = 0;
    while (!stbn && low < 50) begin
      @(posedge clk); #1;
      low++;
    end
    check_int("stb_width", low, STBW);
    ibf = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check8("pa_hold", pa_dout, b);
      check1("tx_ready_hold", tx_ready, 1'b0);
    end
    check1("busy_hold", busy, 1'b1);
    rd = pa_dout;
    check8("cpu_read", rd, b);
    ibf = 1'b0;
    @(posedge clk); #1;
    check1("tx_ready_after_read", tx_ready, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    logic [7:0] bp_bytes [5];
    bp_bytes[0] = 8'ha0; bp_bytes[1] = 8'ha1; bp_bytes[2] = 8'ha2;
    bp_bytes[3] = 8'ha3; bp_bytes[4] = 8'ha4;

    rst_n = 1'b0; obfn = 1'b1; pa_din = 8'h00; ibf = 1'b0;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_ackn", ackn, 1'b1);
    check1("rst_stbn", stbn, 1'b1);
    check8("rst_pa_dout", pa_dout, 8'hff);
    check1("rst_rx_valid", rx_valid, 1'b0);
    check_int("rst_rx_cnt", int'(rx_cnt), 0);
    check1("rst_tx_ready", tx_ready, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check1("idle_ackn", ackn, 1'b1);
    check1("idle_stbn", stbn, 1'b1);
    check8("idle_pa_dout", pa_dout, 8'hff);
    check_int("idle_rx_cnt", int'(rx_cnt), 0);
    check1("idle_busy", busy, 1'b0);
    check1("idle_tx_ready", tx_ready, 1'b1);

    // Single RX byte.
    cpu_write(8'h5a);
    check8("rx1_data", rx_data, 8'h5a);
    check1("rx1_valid", rx_valid, 1'b1);
    check_int("rx1_cnt", int'(rx_cnt), 1);
    pop_one(8'h5a);
    check1("rx1_popped", rx_valid, 1'b0);

    // Fill the FIFO, then a fifth write must stall until a slot frees.
    for (int i = 0; i < 4; i++) cpu_write(bp_bytes[i]);
    check_int("bp_full_cnt", int'(rx_cnt), 4);
    cpu_write_begin(bp_bytes[4]);
    repeat (5) begin
      @(posedge clk); #1;
      check1("bp_no_ack", ackn, 1'b1);
      check_int("bp_cnt_held", int'(rx_cnt), 4);
    end
    pop_one(bp_bytes[0]);
    cpu_write_finish(lat);
    check_int("bp_ack_latency", lat, 1);
    check_int("bp_cnt_refill", int'(rx_cnt), 4);
    for (int i = 1; i < 5; i++) pop_one(bp_bytes[i]);
    check1("bp_drained", rx_valid, 1'b0);

    // Single TX byte.
    send_tx(8'hc3);
    check1("tx1_idle", busy, 1'b0);

    // Mode 2: both directions start in the same cycle.
    fork
      cpu_write(8'h11);
      send_tx(8'h22);
    join
    check8("m2_rx_data", rx_data, 8'h11);
    pop_one(8'h11);

    // Reset during RX_ACK and TX_STB.
    cpu_write_begin(8'h77);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    check1("pre_rst_ackn", ackn, 1'b0);
    check1("pre_rst_stbn", stbn, 1'b0);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_ackn", ackn, 1'b1);
    check1("mid_rst_stbn", stbn, 1'b1);
    check8("mid_rst_pa_dout", pa_dout, 8'hff);
    check_int("mid_rst_rx_cnt", int'(rx_cnt), 0);
    check1("mid_rst_rx_valid", rx_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    obfn = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("post_rst_busy", busy, 1'b0);
    check_int("post_rst_rx_cnt", int'(rx_cnt), 0);
    check1("post_rst_ackn", ackn, 1'b1);
    check1("post_rst_tx_ready", tx_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
